// File: rtl/tristate_bus_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM state encoding and
// parameter legality checks used at elaboration time.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  function automatic bit params_legal(input int n_req, input int max_hold,
                                      input int turnaround);
    return (n_req >= 2) && (max_hold >= 1) && (turnaround >= 1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: scans req starting one past last_owner,
// wrapping around; the first set bit wins.
module rr_priority_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_owner) + i) % N_REQ);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus: one-hot driver enables
// with bounded ownership and guaranteed idle turnaround between owners.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [N_REQ-1:0]         preempt
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURNAROUND + 1);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LIM = TURN_W'(TURNAROUND);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(N_REQ - 1);

  if (!params_legal(N_REQ, MAX_HOLD, TURNAROUND)) begin : g_bad_params
    $error("tristate_bus_arbiter: need N_REQ>=2, MAX_HOLD>=1, TURNAROUND>=1");
  end

  arb_state_e        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_nxt;
  logic [IDX_W-1:0]  last_owner, last_nxt;
  logic [N_REQ-1:0]  grant_nxt, preempt_nxt;
  logic [IDX_W-1:0]  owner_nxt;
  logic              busy_nxt;
  logic              pick_pt;
  logic              found;
  logic [IDX_W-1:0]  winner;

  rr_priority_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req       (req),
    .last_owner(last_owner),
    .found     (found),
    .winner    (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      last_owner <= LAST_RST;
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      preempt    <= '0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      turn_cnt   <= turn_nxt;
      last_owner <= last_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      busy       <= busy_nxt;
      preempt    <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    turn_nxt    = turn_cnt;
    last_nxt    = last_owner;
    grant_nxt   = grant;
    owner_nxt   = owner;
    busy_nxt    = busy;
    preempt_nxt = '0;
    pick_pt     = 1'b0;

    case (state)
      IDLE: pick_pt = 1'b1;
      OWN: begin
        // A voluntary drop takes precedence over hold expiry: no preempt then.
        if (!req[owner] || (hold_cnt == HOLD_LIM)) begin
          if (req[owner]) preempt_nxt[owner] = 1'b1;
          state_nxt = TURN;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          owner_nxt = '0;
          hold_nxt  = '0;
          turn_nxt  = TURN_W'(1);
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt < TURN_LIM) turn_nxt = turn_cnt + 1'b1;
        else                     pick_pt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (pick_pt) begin
      if (found) begin
        state_nxt         = OWN;
        grant_nxt         = '0;
        grant_nxt[winner] = 1'b1;
        owner_nxt         = winner;
        last_nxt          = winner;
        busy_nxt          = 1'b1;
        hold_nxt          = HOLD_W'(1);
        turn_nxt          = '0;
      end else begin
        state_nxt = IDLE;
        turn_nxt  = '0;
      end
    end
  end

endmodule
